// File: rtl/rx_byte_buffer.sv
// rx_byte_buffer
//   Receive-side byte buffer between uart_rx and the display path. Each byte
//   flagged by rdrf is acknowledged with a one-cycle rdrf_clr pulse; bytes
//   without a framing error are stored in a circular FIFO whose oldest entry
//   is presented on dout (show-ahead). A one-cycle pop discards the head.
//
// Ports
//   clk        system clock (clk25)
//   clr        synchronous active-low reset
//   rdrf       receive-data-register-full from uart_rx
//   rx_data    received byte, valid while rdrf = 1
//   FE         framing error qualifying rx_data
//   pop        one-cycle request to discard the head entry
//   err_clr    one-cycle pulse clearing overflow and frame_err
//   rdrf_clr   acknowledge to uart_rx, one cycle per accepted rdrf
//   dout       head-of-FIFO byte, 0x00 when empty
//   count      occupied entries, 0..DEPTH
//   empty      count = 0
//   full       count = DEPTH
//   overflow   sticky: good byte arrived while no room
//   frame_err  sticky: byte arrived with FE = 1
module rx_byte_buffer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          rdrf,
  input  logic [7:0]    rx_data,
  input  logic          FE,
  input  logic          pop,
  input  logic          err_clr,
  output logic          rdrf_clr,
  output logic [7:0]    dout,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          frame_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          frame_err_q, frame_err_d;
  logic [7:0]    mem_q [DEPTH];

  logic          capture;
  logic          pop_ok;
  logic          room;
  logic          wr_en;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    frame_err_d = frame_err_q;
    capture     = 1'b0;
    pop_ok      = 1'b0;
    room        = 1'b0;
    wr_en       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rdrf) begin
          capture = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK:   state_d = S_WAIT;
      S_WAIT:  if (!rdrf) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A pop on the capture edge frees the slot the write needs when full;
    // a pop while empty is ignored so a same-edge write still lands.
    pop_ok = pop && (count_q != '0);
    room   = (count_q != CNT_FULL) || pop_ok;
    wr_en  = capture && !FE && room;

    if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr_en)  wr_ptr_d = wr_ptr_q + PTR_ONE;

    case ({wr_en, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Set has priority over err_clr on the same edge.
    if (err_clr) begin
      overflow_d  = 1'b0;
      frame_err_d = 1'b0;
    end
    if (capture && FE)          frame_err_d = 1'b1;
    if (capture && !FE && !room) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (clr && wr_en) mem_q[wr_ptr_q] <= rx_data;
  end

  assign rdrf_clr  = (state_q == S_ACK);
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_FULL);
  assign dout      = empty ? '0 : mem_q[rd_ptr_q];
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_rx_byte_buffer.sv
// tb_rx_byte_buffer
//   Directed bench for rx_byte_buffer. A queue holds the bytes expected in
//   the FIFO; writes push to it when stimulus is driven, pops compare the
//   head with dout and remove it. Flags are tracked alongside.
module tb_rx_byte_buffer;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          clr, rdrf, FE, pop, err_clr;
  logic [7:0]    rx_data;
  logic          rdrf_clr, empty, full, overflow, frame_err;
  logic [7:0]    dout;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [$];
  logic exp_ovf = 1'b0;
  logic exp_fe  = 1'b0;

  rx_byte_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .clr(clr), .rdrf(rdrf), .rx_data(rx_data), .FE(FE),
    .pop(pop), .err_clr(err_clr), .rdrf_clr(rdrf_clr), .dout(dout),
    .count(count), .empty(empty), .full(full), .overflow(overflow),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] head();
    return (sb.size() > 0) ? sb[0] : 8'h00;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(sb.size()));
    chk({tag, ".dout"}, 32'(dout), 32'(head()));
    chk({tag, ".empty"}, 32'(empty), 32'(sb.size() == 0));
    chk({tag, ".full"}, 32'(full), 32'(sb.size() == DEPTH));
    chk({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, ".frame_err"}, 32'(frame_err), 32'(exp_fe));
  endtask

  // Drive rdrf at a negedge; the capture edge follows. Model updated to
  // what that edge must do, then state checked one edge later.
  task automatic start(input logic [7:0] data, input logic fe, input logic p, input string tag);
    logic pv, rm;
    @(negedge clk);
    if (p) chk({tag, ".pre_pop_dout"}, 32'(dout), 32'(head()));
    rdrf = 1'b1; rx_data = data; FE = fe; pop = p;
    pv = p && (sb.size() > 0);
    rm = (sb.size() < DEPTH) || pv;
    if (pv) void'(sb.pop_front());
    if (fe)      exp_fe = 1'b1;
    else if (rm) sb.push_back(data);
    else         exp_ovf = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    check_state(tag);
  endtask

  // Wait (bounded) for the acknowledge, keep rdrf high for hold extra
  // cycles, drop it, and require exactly one rdrf_clr cycle overall.
  task automatic tail(input int hold, input string tag);
    int pulses = 0;
    int n = 0;
    while (rdrf_clr !== 1'b1 && n < 4) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".ack_seen"}, 32'(rdrf_clr), 32'd1);
    pulses = (rdrf_clr === 1'b1) ? 1 : 0;
    @(negedge clk);
    pulses += (rdrf_clr === 1'b1) ? 1 : 0;
    repeat (hold) begin
      @(negedge clk);
      pulses += (rdrf_clr === 1'b1) ? 1 : 0;
    end
    rdrf = 1'b0;
    repeat (3) begin
      @(negedge clk);
      pulses += (rdrf_clr === 1'b1) ? 1 : 0;
    end
    chk({tag, ".ack_pulses"}, 32'(pulses), 32'd1);
    check_state({tag, ".after"});
  endtask

  task automatic send(input logic [7:0] data, input logic fe, input logic p,
                      input int hold, input string tag);
    start(data, fe, p, tag);
    tail(hold, tag);
  endtask

  task automatic do_pop(input string tag);
    @(negedge clk);
    chk({tag, ".pre_dout"}, 32'(dout), 32'(head()));
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    if (sb.size() > 0) void'(sb.pop_front());
    check_state(tag);
  endtask

  initial begin
    clr = 1'b0; rdrf = 1'b0; FE = 1'b0; pop = 1'b0; err_clr = 1'b0;
    rx_data = 8'h00;

    // Reset
    repeat (2) @(negedge clk);
    check_state("reset");
    chk("reset.rdrf_clr", 32'(rdrf_clr), 32'd0);
    clr = 1'b1;

    // Single byte, rdrf held 5 extra cycles
    send(8'h41, 1'b0, 1'b0, 5, "single");
    do_pop("single_pop");

    // Fill, overflow, drain
    for (int unsigned i = 1; i <= 9; i++) send(8'(i), 1'b0, 1'b0, 0, $sformatf("fill%0d", i));
    for (int unsigned i = 1; i <= 8; i++) do_pop($sformatf("drain%0d", i));
    do_pop("drain_extra");

    // Framing error, then clear both stickies
    send(8'h55, 1'b1, 1'b0, 0, "frame");
    @(negedge clk);
    err_clr = 1'b1;
    exp_fe = 1'b0; exp_ovf = 1'b0;
    @(negedge clk);
    err_clr = 1'b0;
    check_state("err_clr");

    // Full FIFO: write with same-edge pop
    for (int unsigned i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b0, 1'b0, 0, $sformatf("refill%0d", i));
    send(8'hAA, 1'b0, 1'b1, 0, "full_wr_pop");
    for (int unsigned i = 0; i < 8; i++) do_pop($sformatf("drain_aa%0d", i));

    // Empty FIFO: write with same-edge pop
    send(8'h33, 1'b0, 1'b1, 0, "empty_wr_pop");
    do_pop("pop33");

    // Stream across pointer wrap with interleaved pops
    for (int unsigned i = 0; i < 20; i++) begin
      send(8'(i * 7 + 3), 1'b0, 1'b0, 0, $sformatf("stream%0d", i));
      if (i % 3 != 0) do_pop($sformatf("spop%0d", i));
    end
    while (sb.size() > 0) do_pop("sdrain");

    // Reset while in WAIT with rdrf still high
    send(8'h77, 1'b0, 1'b0, 0, "pre_rst");
    @(negedge clk);
    rdrf = 1'b1; rx_data = 8'h5A; FE = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    sb.delete(); exp_ovf = 1'b0; exp_fe = 1'b0;
    check_state("mid_rst");
    chk("mid_rst.rdrf_clr", 32'(rdrf_clr), 32'd0);
    clr = 1'b1;
    sb.push_back(8'h5A);
    @(negedge clk);
    check_state("recapture");
    tail(0, "recapture");
    do_pop("recapture_pop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
